// File: rtl/pipe_ctrl_pkg.sv
//==============================================================================
// pipe_ctrl_pkg - shared types and constants for the ARMv4 pipeline sequencer. Rev 1.0
//==============================================================================
`default_nettype none

package pipe_ctrl_pkg;

    localparam int LDM_CNT_W = 5;
    localparam int RF_CODE_W = 4;
    localparam int LDM_IDX_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LDM   = 2'd1,
        ST_SWP_W = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_bubble;
    } stage_ctrl_t;

    // CTRL_FLUSH is the NOP/bubble load shared with the IF/ID logic
    localparam stage_ctrl_t CTRL_HOLD   = 7'b00000_00;
    localparam stage_ctrl_t CTRL_RUN    = 7'b11111_00;
    localparam stage_ctrl_t CTRL_FLUSH  = 7'b11111_11;
    localparam stage_ctrl_t CTRL_BUBBLE = 7'b00111_01;
    localparam stage_ctrl_t CTRL_ISSUE  = 7'b00111_00;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_cmp.sv
//==============================================================================
// pipe_hazard_cmp - load-use comparator of decode sources against the EX load destination. Rev 1.0
//==============================================================================
`default_nettype none

module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic                 i_ex_load,
    input  logic                 i_id_vld,
    input  logic                 i_rn_vld,
    input  logic                 i_rm_vld,
    input  logic                 i_rs_vld,
    input  logic [RF_CODE_W-1:0] i_rn_code,
    input  logic [RF_CODE_W-1:0] i_rm_code,
    input  logic [RF_CODE_W-1:0] i_rs_code,
    input  logic [RF_CODE_W-1:0] i_ex_rd_code,
    output logic                 o_hazard
);

    logic w_rn_hit;
    logic w_rm_hit;
    logic w_rs_hit;

    assign w_rn_hit = i_rn_vld && (i_rn_code == i_ex_rd_code);
    assign w_rm_hit = i_rm_vld && (i_rm_code == i_ex_rd_code);
    assign w_rs_hit = i_rs_vld && (i_rs_code == i_ex_rd_code);

    assign o_hazard = i_ex_load && i_id_vld && (w_rn_hit || w_rm_hit || w_rs_hit);

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
//==============================================================================
// pipe_ctrl - ARMv4 pipeline sequencer (enables, flush, LDM/SWP, IRQ gating);
// define PIPE_PERF_CNT_EN for stall/flush counters. Rev 1.0
//==============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_id_vld,
    input  logic                 i_id_rn_vld,
    input  logic                 i_id_rm_vld,
    input  logic                 i_id_rs_vld,
    input  logic [RF_CODE_W-1:0] i_id_rn_code,
    input  logic [RF_CODE_W-1:0] i_id_rm_code,
    input  logic [RF_CODE_W-1:0] i_id_rs_code,
    input  logic                 i_id_ldm_vld,
    input  logic [LDM_CNT_W-1:0] i_id_ldm_cnt,
    input  logic                 i_id_swp_vld,
    input  logic                 i_ex_load,
    input  logic [RF_CODE_W-1:0] i_ex_rd_code,
    input  logic                 i_br_taken,
    input  logic                 i_mem_busy,
    input  logic                 i_irq,
    input  logic                 i_cpsr_i,
    output logic                 o_pc_en,
    output logic                 o_if_id_en,
    output logic                 o_id_ex_en,
    output logic                 o_ex_mem_en,
    output logic                 o_mem_wb_en,
    output logic                 o_if_id_flush,
    output logic                 o_id_ex_bubble,
    output logic [LDM_IDX_W-1:0] o_ldm_idx,
    output logic                 o_ldm_last,
    output logic                 o_swp_phase,
    output logic                 o_irq_flag,
    output logic                 o_busy
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]          o_stall_cnt,
    output logic [31:0]          o_flush_cnt
`endif
);

    pipe_state_e          state_q, state_d;
    logic [LDM_IDX_W-1:0] idx_q, idx_d;
    logic [LDM_IDX_W-1:0] last_idx_q, last_idx_d;
    logic                 irq_pend_q, irq_pend_d;

    logic                 w_hazard;
    logic [LDM_CNT_W-1:0] w_cnt_m1;
    logic [LDM_IDX_W-1:0] w_last_idx;
    stage_ctrl_t          w_ctrl;
    logic                 w_ldm_last;
    logic                 w_swp_phase;
    logic                 w_irq_flag;

    pipe_hazard_cmp u_hazard (
        .i_ex_load    (i_ex_load),
        .i_id_vld     (i_id_vld),
        .i_rn_vld     (i_id_rn_vld),
        .i_rm_vld     (i_id_rm_vld),
        .i_rs_vld     (i_id_rs_vld),
        .i_rn_code    (i_id_rn_code),
        .i_rm_code    (i_id_rm_code),
        .i_rs_code    (i_id_rs_code),
        .i_ex_rd_code (i_ex_rd_code),
        .o_hazard     (w_hazard)
    );

    // Count 0 wraps to 16; anything above 16 clamps to the 16-beat maximum
    assign w_cnt_m1   = i_id_ldm_cnt - 5'd1;
    assign w_last_idx = w_cnt_m1[LDM_CNT_W-1] ? 4'hF : w_cnt_m1[LDM_IDX_W-1:0];

    always_comb begin
        w_ctrl      = CTRL_HOLD;
        state_d     = state_q;
        idx_d       = idx_q;
        last_idx_d  = last_idx_q;
        w_ldm_last  = 1'b0;
        w_swp_phase = 1'b0;
        if (i_mem_busy) begin
            w_ctrl = CTRL_HOLD;
        end else if (i_br_taken) begin
            w_ctrl  = CTRL_FLUSH;
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_LDM: begin
                    w_ldm_last = (idx_q == last_idx_q);
                    if (w_ldm_last) begin
                        w_ctrl  = CTRL_RUN;
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else begin
                        w_ctrl = CTRL_ISSUE;
                        idx_d  = idx_q + 4'd1;
                    end
                end
                ST_SWP_W: begin
                    w_swp_phase = 1'b1;
                    w_ctrl      = CTRL_RUN;
                    state_d     = ST_IDLE;
                end
                default: begin
                    if (w_hazard) begin
                        w_ctrl = CTRL_BUBBLE;
                    end else if (i_id_vld && i_id_ldm_vld) begin
                        if (w_last_idx != '0) begin
                            w_ctrl     = CTRL_ISSUE;
                            state_d    = ST_LDM;
                            idx_d      = 4'd1;
                            last_idx_d = w_last_idx;
                        end else begin
                            w_ctrl     = CTRL_RUN;
                            w_ldm_last = 1'b1;
                        end
                    end else if (i_id_vld && i_id_swp_vld) begin
                        w_ctrl  = CTRL_ISSUE;
                        state_d = ST_SWP_W;
                    end else begin
                        w_ctrl = CTRL_RUN;
                    end
                end
            endcase
        end
    end

    // Only an instruction advancing unhindered out of IDLE may carry the IRQ tag
    assign w_irq_flag = irq_pend_q && (state_q == ST_IDLE) && i_id_vld && (w_ctrl == CTRL_RUN);
    assign irq_pend_d = i_irq && !i_cpsr_i && !w_irq_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            last_idx_q <= '0;
            irq_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign o_pc_en        = rst_n && w_ctrl.pc_en;
    assign o_if_id_en     = rst_n && w_ctrl.if_id_en;
    assign o_id_ex_en     = rst_n && w_ctrl.id_ex_en;
    assign o_ex_mem_en    = rst_n && w_ctrl.ex_mem_en;
    assign o_mem_wb_en    = rst_n && w_ctrl.mem_wb_en;
    assign o_if_id_flush  = rst_n && w_ctrl.if_id_flush;
    assign o_id_ex_bubble = rst_n && w_ctrl.id_ex_bubble;
    assign o_ldm_idx      = idx_q;
    assign o_ldm_last     = rst_n && w_ldm_last;
    assign o_swp_phase    = w_swp_phase;
    assign o_irq_flag     = rst_n && w_irq_flag;
    assign o_busy         = (state_q != ST_IDLE);

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!w_ctrl.pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (w_ctrl.if_id_flush && (flush_cnt_q != 32'hFFFF_FFFF)) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
//==============================================================================
// tb_pipe_ctrl - directed and random stimulus against a behavioural sequencer model. Rev 1.0
//==============================================================================
`default_nettype none

module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       id_vld, rn_vld, rm_vld, rs_vld;
    logic [3:0] rn_code, rm_code, rs_code;
    logic       ldm_vld;
    logic [4:0] ldm_cnt;
    logic       swp_vld, ex_load;
    logic [3:0] ex_rd;
    logic       br, mem_busy, irq, cpsr_i;

    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble;
    logic [3:0] ldm_idx;
    logic       ldm_last, swp_phase, irq_flag, busy;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    pipe_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_id_vld       (id_vld),
        .i_id_rn_vld    (rn_vld),
        .i_id_rm_vld    (rm_vld),
        .i_id_rs_vld    (rs_vld),
        .i_id_rn_code   (rn_code),
        .i_id_rm_code   (rm_code),
        .i_id_rs_code   (rs_code),
        .i_id_ldm_vld   (ldm_vld),
        .i_id_ldm_cnt   (ldm_cnt),
        .i_id_swp_vld   (swp_vld),
        .i_ex_load      (ex_load),
        .i_ex_rd_code   (ex_rd),
        .i_br_taken     (br),
        .i_mem_busy     (mem_busy),
        .i_irq          (irq),
        .i_cpsr_i       (cpsr_i),
        .o_pc_en        (pc_en),
        .o_if_id_en     (if_id_en),
        .o_id_ex_en     (id_ex_en),
        .o_ex_mem_en    (ex_mem_en),
        .o_mem_wb_en    (mem_wb_en),
        .o_if_id_flush  (if_id_flush),
        .o_id_ex_bubble (id_ex_bubble),
        .o_ldm_idx      (ldm_idx),
        .o_ldm_last     (ldm_last),
        .o_swp_phase    (swp_phase),
        .o_irq_flag     (irq_flag),
        .o_busy         (busy)
`ifdef PIPE_PERF_CNT_EN
        ,
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: LDM beats still owed, next beat number, owed SWP write, IRQ pending
    int   m_left, m_beat, n_left, n_beat;
    bit   m_swp_wr, n_swp_wr, m_pend, n_pend;
    logic [6:0] e_ctrl;
    int   e_idx;
    bit   e_last, e_phase, e_irq, e_busy;
    longint m_stall, m_flush;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        id_vld = 0; rn_vld = 0; rm_vld = 0; rs_vld = 0;
        rn_code = 0; rm_code = 0; rs_code = 0;
        ldm_vld = 0; ldm_cnt = 0; swp_vld = 0;
        ex_load = 0; ex_rd = 0; br = 0; mem_busy = 0; irq = 0; cpsr_i = 0;
    endtask

    task automatic model_eval();
        bit hz;
        int n;
        bit [3:0] codes [3];
        bit       vlds  [3];
        codes = '{rn_code, rm_code, rs_code};
        vlds  = '{rn_vld, rm_vld, rs_vld};
        e_ctrl = '0; e_idx = 0; e_last = 0; e_phase = 0; e_irq = 0; e_busy = 0;
        if (!rst_n) begin
            m_left = 0; m_beat = 0; m_swp_wr = 0; m_pend = 0;
            n_left = 0; n_beat = 0; n_swp_wr = 0; n_pend = 0;
        end else begin
            n_left = m_left; n_beat = m_beat; n_swp_wr = m_swp_wr;
            e_busy = (m_left > 0) || m_swp_wr;
            if (m_left > 0) e_idx = m_beat;
            hz = 0;
            for (int k = 0; k < 3; k++)
                if (ex_load && id_vld && vlds[k] && codes[k] == ex_rd) hz = 1;
            if (mem_busy) begin
                e_ctrl = 7'b0000000;
            end else if (br) begin
                e_ctrl = 7'b1111111; n_left = 0; n_beat = 0; n_swp_wr = 0;
            end else if (m_left > 0) begin
                e_last = (m_left == 1);
                e_ctrl = {e_last, e_last, 5'b11100};
                n_left = m_left - 1;
                n_beat = e_last ? 0 : m_beat + 1;
            end else if (m_swp_wr) begin
                e_phase = 1; e_ctrl = 7'b1111100; n_swp_wr = 0;
            end else if (hz) begin
                e_ctrl = 7'b0011101;
            end else if (id_vld && ldm_vld) begin
                n = (ldm_cnt == 0) ? 16 : int'(ldm_cnt);
                if (n > 1) begin
                    e_ctrl = 7'b0011100; n_left = n - 1; n_beat = 1;
                end else begin
                    e_ctrl = 7'b1111100; e_last = 1; e_irq = m_pend;
                end
            end else if (id_vld && swp_vld) begin
                e_ctrl = 7'b0011100; n_swp_wr = 1;
            end else begin
                e_ctrl = 7'b1111100; e_irq = m_pend && id_vld;
            end
            n_pend = irq && !cpsr_i && !e_irq;
        end
    endtask

    // Inputs are set at the falling edge; check 1ns later, advance model at the rising edge
    task automatic cycle();
        #1;
        model_eval();
        chk("ctrl", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble}, e_ctrl);
        chk("ldm_idx", ldm_idx, e_idx);
        chk("ldm_last", ldm_last, e_last);
        chk("swp_phase", swp_phase, e_phase);
        chk("irq_flag", irq_flag, e_irq);
        chk("busy", busy, e_busy);
`ifdef PIPE_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, m_stall[31:0]);
        chk("flush_cnt", flush_cnt, m_flush[31:0]);
`endif
        @(posedge clk);
        if (rst_n) begin
            if (!e_ctrl[6] && m_stall < 64'hFFFF_FFFF) m_stall++;
            if (e_ctrl[1] && m_flush < 64'hFFFF_FFFF) m_flush++;
        end else begin
            m_stall = 0; m_flush = 0;
        end
        m_left = n_left; m_beat = n_beat; m_swp_wr = n_swp_wr; m_pend = n_pend;
        @(negedge clk);
    endtask

    task automatic start_ldm(input logic [4:0] cnt);
        clear_inputs();
        id_vld = 1; ldm_vld = 1; ldm_cnt = cnt;
        cycle();
        clear_inputs();
    endtask

    initial begin
        m_left = 0; m_beat = 0; m_swp_wr = 0; m_pend = 0; m_stall = 0; m_flush = 0;
        clear_inputs();
        @(negedge clk);
        id_vld = 1;
        cycle(); cycle();
        rst_n = 1;
        cycle();

        // Load-use: EX loads r3, decode ADD r1,r3,r2
        ex_load = 1; ex_rd = 3; id_vld = 1; rn_vld = 1; rn_code = 3; rm_vld = 1; rm_code = 2;
        cycle();
        ex_load = 0;
        cycle();

        // LDM of four registers
        start_ldm(5'd4);
        repeat (4) cycle();

        // LDM of four with two wait-states at beat 1
        start_ldm(5'd4);
        mem_busy = 1; cycle(); cycle();
        mem_busy = 0; repeat (3) cycle();

        // SWP read then write
        clear_inputs(); id_vld = 1; swp_vld = 1; cycle();
        clear_inputs(); repeat (2) cycle();

        // Branch taken on LDM beat 2
        start_ldm(5'd4);
        cycle();
        br = 1; cycle();
        br = 0; repeat (2) cycle();

        // IRQ unmasked, then masked
        id_vld = 1; irq = 1; cpsr_i = 0; repeat (3) cycle();
        irq = 0; cycle();
        irq = 1; cpsr_i = 1; repeat (3) cycle();
        clear_inputs();

        // Single-beat, 16-beat (count 0) and load-use colliding with LDM start
        start_ldm(5'd1); cycle();
        start_ldm(5'd0); repeat (16) cycle();
        id_vld = 1; ldm_vld = 1; ldm_cnt = 3; ex_load = 1; ex_rd = 5; rs_vld = 1; rs_code = 5;
        cycle();
        ex_load = 0; cycle();
        clear_inputs(); repeat (3) cycle();

        // Asynchronous reset in the middle of an LDM
        start_ldm(5'd8);
        repeat (2) cycle();
        rst_n = 0; cycle();
        rst_n = 1; repeat (2) cycle();

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            id_vld   = ($urandom_range(0, 9) < 8);
            rn_vld   = $urandom_range(0, 1); rn_code = 4'($urandom_range(0, 3));
            rm_vld   = $urandom_range(0, 1); rm_code = 4'($urandom_range(0, 3));
            rs_vld   = $urandom_range(0, 1); rs_code = 4'($urandom_range(0, 3));
            ldm_vld  = ($urandom_range(0, 99) < 15);
            ldm_cnt  = 5'($urandom_range(0, 16));
            swp_vld  = ($urandom_range(0, 9) == 0);
            ex_load  = ($urandom_range(0, 9) < 3);
            ex_rd    = 4'($urandom_range(0, 3));
            br       = ($urandom_range(0, 99) < 8);
            mem_busy = ($urandom_range(0, 99) < 15);
            irq      = $urandom_range(0, 1);
            cpsr_i   = ($urandom_range(0, 9) < 3);
            rst_n    = ($urandom_range(0, 199) != 0);
            cycle();
        end
        rst_n = 1;
        clear_inputs();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline sequencer for the ARMv4 core.
- Generates per-stage enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Sequences multi-cycle instructions (LDM/STM beats, SWP read/write phases), inserts load-use interlock bubbles, flushes on taken branch/PC write, and gates IRQ entry.
- Sits beside the decode stage; its enables drive every pipeline register's en input.

Parameters:
- LDM_CNT_W, 5, width of LDM/STM register count (1..16)
- RF_CODE_W, 4, register code width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; rst_n asynchronous, active-low; clock clk
- i_id_vld  in  1  decode stage holds a valid instruction
- i_id_rn_vld / i_id_rm_vld / i_id_rs_vld  in  1 each  source operand used
- i_id_rn_code / i_id_rm_code / i_id_rs_code  in  4 each  source register codes
- i_id_ldm_vld  in  1  decode is LDM/STM
- i_id_ldm_cnt  in  5  registers in list, 1..16
- i_id_swp_vld  in  1  decode is SWP/SWPB
- i_ex_load  in  1  EX holds a load writing i_ex_rd_code
- i_ex_rd_code  in  4  EX destination
- i_br_taken  in  1  EX resolved PC write/branch taken
- i_mem_busy  in  1  data memory wait-state
- i_irq  in  1  external IRQ level
- i_cpsr_i  in  1  CPSR I mask
- o_pc_en, o_if_id_en, o_id_ex_en, o_ex_mem_en, o_mem_wb_en  out  1 each  stage enables
- o_if_id_flush  out  1  IF/ID loads a NOP
- o_id_ex_bubble  out  1  ID/EX loads all valid bits = 0
- o_ldm_idx  out  4  current LDM beat index
- o_ldm_last  out  1  final LDM beat
- o_swp_phase  out  1  0 = read phase, 1 = write phase
- o_irq_flag  out  1  tag decode instruction as IRQ entry (to ID/EX i_irq_flag)
- o_busy  out  1  multi-cycle sequence in progress

Behaviour:
- States: IDLE, LDM, SWP_W.
- Reset: state IDLE, ldm counter 0, swp phase 0, irq pending 0. While rst_n low, all enables, flushes and bubble read 0, and o_irq_flag reads 0.
- All outputs are combinational from registered state plus same-cycle inputs. State updates on posedge clk.
- Priority each cycle: mem_busy > br_taken > multi-cycle > load-use > normal.
- mem_busy: all enables 0, no flush, state/counters frozen. A branch arriving during busy is held by EX and acted on once busy drops.
- br_taken (not busy):
  - o_pc_en = 1, o_if_id_flush = 1, o_id_ex_bubble = 1, downstream enables = 1.
  - Aborts LDM/SWP in decode: state returns to IDLE, idx cleared.
- Load-use: i_ex_load && i_id_vld && any (src_vld && src_code == i_ex_rd_code) gives o_pc_en = 0, o_if_id_en = 0, o_id_ex_en = 1 with o_id_ex_bubble = 1, downstream enables 1. Exactly one bubble per hazard; the stall repeats naturally if the hazard persists.
- IDLE:
  - LDM decode with cnt > 1: enter LDM, idx = 0, freeze PC/IF/ID, ID/EX enabled (emits beat 0).
  - cnt == 1: single beat, o_ldm_last = 1, stay IDLE.
  - SWP decode: freeze PC/IF/ID, emit read phase (swp_phase = 0), enter SWP_W.
- LDM: each un-stalled cycle idx++.
  - o_ldm_last = (idx == cnt-1).
  - On the last beat, release PC/IF/ID and return to IDLE.
  - cnt latched on entry; cnt 0 is treated as 16 (wraps).
- SWP_W: emit write phase (swp_phase = 1), release PC/IF/ID, go IDLE.
- o_busy = 1 in LDM and SWP_W.
- IRQ:
  - irq pending register = i_irq & ~i_cpsr_i, sampled each cycle.
  - o_irq_flag = pending && IDLE && i_id_vld && no stall/flush.
  - Never asserted mid LDM/SWP.
  - Pending clears when i_irq drops or the flagged instruction advances.
- Simultaneous load-use and LDM start: load-use wins; LDM starts the following cycle.
- Async reset mid-sequence aborts to IDLE immediately.

Optional Feature:
- PIPE_PERF_CNT_EN defined: adds outputs o_stall_cnt[31:0] (cycles with o_pc_en = 0 excluding reset) and o_flush_cnt[31:0] (branch flushes). Both are 0 on reset and saturate at 0xFFFF_FFFF.
- Undefined: no counters and no ports.

Decomposition:
- Package pipe_ctrl_pkg holds:
  - the state enum (IDLE, LDM, SWP_W)
  - LDM_CNT_W and RF_CODE_W
  - an NOP/bubble constant shared with the IF/ID logic
- Sub-module pipe_hazard_cmp: combinational load-use comparator (three source compares against the EX destination).

Test Plan:
- Load-use: EX load r3, decode ADD r1,r3,r2 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_bubble = 1; next cycle normal.
- LDM cnt = 4 -> idx 0,1,2,3 on consecutive cycles; ldm_last on idx 3; o_busy high 3 cycles; pc_en low 3 cycles.
- LDM cnt = 4 with mem_busy high 2 cycles at idx = 1 -> idx holds at 1 for 2 cycles, all enables 0, then resumes to 3.
- SWP -> swp_phase 0 then 1; PC frozen exactly 1 cycle.
- br_taken during LDM idx = 2 -> if_id_flush = 1, id_ex_bubble = 1, state IDLE next cycle, idx = 0.
- i_irq = 1, cpsr_i = 0, idle -> o_irq_flag = 1 next cycle. With cpsr_i = 1 -> o_irq_flag stays 0.
- rst_n low mid-LDM -> all enables 0 immediately, state IDLE after release.
